// File: rtl/line_scaler_sync.sv
// line_scaler_sync: captures source pixels into a line ring on clk and replays them on
// clk_pixel at an integer scale, with letterbox border, overlay and RGB555->888 expansion.
// Also holds the SNES during a refresh window until the HDMI frame reaches its first line,
// giving up after TIMEOUT_CYC clk cycles.
module line_scaler_sync #(
    parameter int          PIXEL_W        = 15,
    parameter int          SRC_W          = 256,
    parameter int          SRC_H          = 224,
    parameter int          BUF_LINES_LOG2 = 4,
    parameter int          SCALE          = 3,
    parameter int          H_START        = 256,
    parameter int          V_START        = 24,
    parameter logic [23:0] BORDER_RGB     = 24'h303030,
    parameter int          SYNC_LINE      = 2,
    parameter int          REARM_LINE     = 200,
    parameter int          TIMEOUT_CYC    = 1048576
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clk_pixel,
    input  logic               pix_valid,
    input  logic [8:0]         src_x,
    input  logic [7:0]         src_y,
    input  logic [PIXEL_W-1:0] pix_data,
    input  logic               snes_refresh,
    input  logic               sync_en,
    input  logic [10:0]        cx,
    input  logic [9:0]         cy,
    input  logic               overlay_en,
    input  logic [14:0]        overlay_color,
    output logic [23:0]        rgb_out,
    output logic               pause_snes,
    output logic [7:0]         sync_timeouts
);
    localparam int BL    = BUF_LINES_LOG2;
    localparam int XW    = $clog2(SRC_W);
    localparam int YW    = $clog2(SRC_H);
    localparam int AW    = BL + XW;
    localparam int TW    = $clog2(TIMEOUT_CYC) + 1;
    localparam int H_END = H_START + SRC_W * SCALE;
    localparam int V_END = V_START + SRC_H * SCALE;

    function automatic logic [23:0] rgb555_to_888(input logic [14:0] p);
        return {p[4:0], p[4:2], p[9:5], p[9:7], p[14:10], p[14:12]};
    endfunction

    // ---------------- capture side (clk) ----------------
    logic               wr_en_q;
    logic [AW-1:0]      wr_addr_q;
    logic [PIXEL_W-1:0] wr_data_q;
    logic [PIXEL_W-1:0] mem [0:(1<<AW)-1];

    // Register the in-range strobe; the ring slot is the low bits of the source line.
    always_ff @(posedge clk) begin
        if (!resetn) wr_en_q <= 1'b0;
        else         wr_en_q <= pix_valid && (src_x < 9'(SRC_W)) && (src_y < 8'(SRC_H));
        wr_addr_q <= {src_y[BL-1:0], src_x[XW-1:0]};
        wr_data_q <= pix_data;
    end

    // BRAM write port, contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
    end

    // ---------------- replay side (clk_pixel) ----------------
    logic [1:0] prst_q;
    logic       prst_n;
    assign prst_n = prst_q[1];

    // Bring resetn into the pixel domain before using it as a synchronous reset.
    always_ff @(posedge clk_pixel) prst_q <= {prst_q[0], resetn};

    logic [XW-1:0] sx_q, sx_d;
    logic [2:0]    phx_q, phx_d;
    logic [YW-1:0] sy_q, sy_d;
    logic [2:0]    phy_q, phy_d;
    logic          h_act, v_act;

    assign h_act = (cx >= 11'(H_START)) && ({1'b0, cx} < 12'(H_END));
    assign v_act = (cy >= 10'(V_START)) && ({1'b0, cy} < 11'(V_END));

    // Source coordinates by phase counting: horizontal restarts at H_START, vertical steps at cx==0.
    always_comb begin
        sx_d  = sx_q;
        phx_d = phx_q;
        if (cx == 11'(H_START)) begin
            sx_d  = '0;
            phx_d = '0;
        end else if (phx_q == 3'(SCALE - 1)) begin
            phx_d = '0;
            sx_d  = sx_q + 1'b1;
        end else begin
            phx_d = phx_q + 1'b1;
        end
        sy_d  = sy_q;
        phy_d = phy_q;
        if (cx == 11'd0) begin
            if (cy == 10'(V_START)) begin
                sy_d  = '0;
                phy_d = '0;
            end else if (v_act) begin
                if (phy_q == 3'(SCALE - 1)) begin
                    phy_d = '0;
                    sy_d  = sy_q + 1'b1;
                end else begin
                    phy_d = phy_q + 1'b1;
                end
            end
        end
    end

    logic [AW-1:0]      rd_addr_q;
    logic               act1_q, act2_q, ovl1_q, ovl2_q;
    logic [14:0]        col1_q, col2_q;
    logic [PIXEL_W-1:0] rd_q;
    logic [23:0]        rgb_q;
    logic               fl_q;

    // Stage 1 (address/flags) and stage 3 (colour); stage 2 flags ride alongside the BRAM read.
    always_ff @(posedge clk_pixel) begin
        if (!prst_n) begin
            sx_q   <= '0;
            phx_q  <= '0;
            sy_q   <= '0;
            phy_q  <= '0;
            act1_q <= 1'b0;
            act2_q <= 1'b0;
            ovl1_q <= 1'b0;
            ovl2_q <= 1'b0;
            rgb_q  <= BORDER_RGB;
            fl_q   <= 1'b0;
        end else begin
            sx_q   <= sx_d;
            phx_q  <= phx_d;
            sy_q   <= sy_d;
            phy_q  <= phy_d;
            act1_q <= h_act && v_act;
            ovl1_q <= overlay_en;
            act2_q <= act1_q;
            ovl2_q <= ovl1_q;
            if (!act2_q)     rgb_q <= BORDER_RGB;
            else if (ovl2_q) rgb_q <= rgb555_to_888(col2_q);
            else             rgb_q <= rgb555_to_888(rd_q[14:0]);
            fl_q   <= (cy == 10'(V_START)) && (cx >= 11'(H_START)) &&
                      ({1'b0, cx} < 12'(H_START + 100));
        end
        rd_addr_q <= {sy_q[BL-1:0], sx_d};
        col1_q    <= overlay_color;
        col2_q    <= col1_q;
    end

    // BRAM read port (stage 2).
    always_ff @(posedge clk_pixel) rd_q <= mem[rd_addr_q];

    assign rgb_out = rgb_q;

    // ---------------- frame-sync FSM (clk) ----------------
    typedef enum logic {S_RUN, S_PAUSE} state_t;
    state_t        state_q;
    logic [1:0]    fls_q;
    logic          par_q, armed_q, pause_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    tcnt_q;

    // first_line is a registered level in clk_pixel; two flops carry it into clk.
    always_ff @(posedge clk) begin
        if (!resetn) fls_q <= 2'b00;
        else         fls_q <= {fls_q[0], fl_q};
    end

    // Pause on the sync line during refresh; release only on an odd parity so the pause is even.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_RUN;
            pause_q <= 1'b0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            armed_q <= 1'b1;
            tcnt_q  <= 8'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (armed_q && sync_en && (src_y == 8'(SYNC_LINE)) && snes_refresh) begin
                        state_q <= S_PAUSE;
                        pause_q <= 1'b1;
                        par_q   <= 1'b0;
                        tmo_q   <= '0;
                    end
                end
                S_PAUSE: begin
                    par_q <= ~par_q;
                    tmo_q <= tmo_q + 1'b1;
                    if (par_q && fls_q[1]) begin
                        state_q <= S_RUN;
                        pause_q <= 1'b0;
                        armed_q <= 1'b0;
                    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        state_q <= S_RUN;
                        pause_q <= 1'b0;
                        armed_q <= 1'b0;
                        if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 1'b1;
                    end else if (par_q && !sync_en) begin
                        state_q <= S_RUN;
                        pause_q <= 1'b0;
                        armed_q <= 1'b0;
                    end
                end
                default: state_q <= S_RUN;
            endcase
            // Re-arm overrides a release clear in the same cycle.
            if (src_y == 8'(REARM_LINE)) armed_q <= 1'b1;
        end
    end

    assign pause_snes    = pause_q;
    assign sync_timeouts = tcnt_q;
endmodule

// File: tb/tb_line_scaler_sync.sv
// Bench for line_scaler_sync: a frame-level pixel model checked every pixel clock,
// plus directed checks of the pause FSM (sync release, timeout, sync_en drop, reset).
module tb_line_scaler_sync;
    localparam int          H = 256, V = 24, S = 3;
    localparam logic [23:0] BORDER = 24'h303030;

    logic        clk = 0, clk_pixel = 0, resetn = 0, pix_valid = 0;
    logic [8:0]  src_x = 0;
    logic [7:0]  src_y = 100;
    logic [14:0] pix_data = 0;
    logic        snes_refresh = 0, sync_en = 1;
    logic [10:0] cx = 2000;
    logic [9:0]  cy = 0;
    logic        overlay_en = 0;
    logic [14:0] overlay_color = 0;
    logic [23:0] rgb_out;
    logic        pause_snes;
    logic [7:0]  sync_timeouts;

    always #5 clk = ~clk;
    always #4 clk_pixel = ~clk_pixel;

    line_scaler_sync #(.TIMEOUT_CYC(64)) u_dut (
        .clk(clk), .resetn(resetn), .clk_pixel(clk_pixel), .pix_valid(pix_valid),
        .src_x(src_x), .src_y(src_y), .pix_data(pix_data), .snes_refresh(snes_refresh),
        .sync_en(sync_en), .cx(cx), .cy(cy), .overlay_en(overlay_en),
        .overlay_color(overlay_color), .rgb_out(rgb_out), .pause_snes(pause_snes),
        .sync_timeouts(sync_timeouts)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- pixel model ----------------
    logic [14:0] mdl_mem   [16][256];
    bit          mdl_known [16][256];

    function automatic logic [23:0] x888(input logic [14:0] p);
        int r, g, b;
        r = int'(p) % 32;
        g = (int'(p) / 32) % 32;
        b = int'(p) / 1024;
        return 24'(((r * 8 + r / 4) << 16) | ((g * 8 + g / 4) << 8) | (b * 8 + b / 4));
    endfunction

    task automatic model(input int x, input int y, input bit ov, input logic [14:0] oc,
                         output logic [23:0] e, output bit k);
        int sx, sy;
        e = BORDER;
        k = 1;
        if (x >= H && x < H + 256 * S && y >= V && y < V + 224 * S) begin
            sx = (x - H) / S;
            sy = (y - V) / S;
            if (ov) e = x888(oc);
            else begin
                k = mdl_known[sy % 16][sx];
                e = x888(mdl_mem[sy % 16][sx]);
            end
        end
    endtask

    logic [23:0] ep_rgb [3];
    bit          ep_k   [3];
    int          ep_cx  [3], ep_cy [3];
    logic [23:0] seen   [2048];
    bit          pchk = 0;

    // Expected output of each pixel-clock input, compared three clocks later.
    initial forever begin
        logic [23:0] e;
        bit          k;
        @(posedge clk_pixel);
        for (int i = 2; i > 0; i--) begin
            ep_rgb[i] = ep_rgb[i-1]; ep_k[i] = ep_k[i-1];
            ep_cx[i]  = ep_cx[i-1];  ep_cy[i] = ep_cy[i-1];
        end
        model(int'(cx), int'(cy), overlay_en, overlay_color, e, k);
        ep_rgb[0] = e; ep_k[0] = k; ep_cx[0] = int'(cx); ep_cy[0] = int'(cy);
        @(negedge clk_pixel);
        if (pchk && ep_k[2]) begin
            check($sformatf("pix cx=%0d cy=%0d", ep_cx[2], ep_cy[2]), rgb_out, ep_rgb[2]);
            seen[ep_cx[2]] = rgb_out;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int x, input int y, input logic [14:0] d);
        @(negedge clk);
        pix_valid = 1; src_x = 9'(x); src_y = 8'(y); pix_data = d;
        if (x < 256 && y < 224) begin
            mdl_mem[y % 16][x]   = d;
            mdl_known[y % 16][x] = 1;
        end
    endtask

    task automatic sweep(input int y, input int c_last, input bit ov, input logic [14:0] oc);
        @(negedge clk_pixel);
        cx = 0; cy = 10'(y); overlay_en = ov; overlay_color = oc;
        for (int c = H; c <= c_last; c++) begin
            @(negedge clk_pixel);
            cx = 11'(c);
        end
        repeat (4) begin
            @(negedge clk_pixel);
            cx = 2000;
        end
        overlay_en = 0;
    endtask

    task automatic strobe_sync();
        @(negedge clk);
        src_y = 2; snes_refresh = 1;
    endtask

    // Counts clk cycles with pause_snes high, starting right after strobe_sync.
    task automatic measure(input int drop_at, output int n);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k == 0) begin src_y = 100; snes_refresh = 0; end
            if (!pause_snes) return;
            n++;
            if (n == drop_at) sync_en = 0;
        end
    endtask

    task automatic rearm();
        @(negedge clk);
        src_y = 200;
        @(negedge clk);
        src_y = 100;
    endtask

    initial begin
        int n;
        repeat (12) @(negedge clk);
        check("reset pause", pause_snes, 0);
        check("reset timeouts", sync_timeouts, 0);
        check("reset rgb", rgb_out, BORDER);
        resetn = 1;
        repeat (4) @(negedge clk);
        pchk = 1;

        for (int x = 0; x < 256; x++) wr(x, 0, 15'(x));
        for (int x = 0; x < 256; x++)
            wr(x, 4, (x == 0) ? 15'h7FFF : (x == 1) ? 15'h001F : 15'(x * 97));
        for (int x = 0; x < 256; x++) wr(x, 17, 15'h1234 ^ 15'(x));
        wr(300, 0, 15'h7FFF);   // column out of range: dropped
        wr(2, 228, 15'h0000);   // line out of range: dropped
        @(negedge clk);
        pix_valid = 0; src_y = 100;
        repeat (3) @(negedge clk);

        // ramp on line 0, tripled horizontally, border past the window
        sweep(24, 1030, 0, 15'h0);
        check("ramp x0 first", seen[256], 24'h000000);
        check("ramp x0 last", seen[258], 24'h000000);
        check("ramp x1", seen[259], 24'h080000);
        check("ramp x37", seen[367], 24'h290800);
        check("ramp x255", seen[1023], 24'hFF3900);
        check("right border", seen[1024], BORDER);

        // line 17 aliases into slot 1, read back at sy=1
        sweep(25, 0, 0, 15'h0);
        sweep(26, 0, 0, 15'h0);
        sweep(27, 300, 0, 15'h0);
        check("alias x0", seen[256], 24'hA58C21);
        check("alias x1", seen[259], 24'hAD8C21);

        // colour expansion extremes and overlay priority on sy=4
        for (int y = 28; y < 36; y++) sweep(y, 0, 0, 15'h0);
        sweep(36, 270, 0, 15'h0);
        check("white", seen[256], 24'hFFFFFF);
        check("red", seen[259], 24'hFF0000);
        sweep(37, 1030, 1, 15'h0000);
        check("overlay black", seen[256], 24'h000000);
        check("overlay border", seen[1024], BORDER);

        // pause released by first_line arriving 37 clk after the pause begins
        strobe_sync();
        fork
            begin repeat (37) @(negedge clk); sweep(24, 355, 0, 15'h0); end
            measure(0, n);
        join
        check("sync pause even", 32'(n % 2), 0);
        check("sync release window", 32'(n >= 39 && n <= 50), 1);
        check("sync no timeout", sync_timeouts, 0);

        // timeout release
        rearm();
        strobe_sync();
        measure(0, n);
        check("timeout length", n, 64);
        check("timeout count", sync_timeouts, 1);
        strobe_sync();
        @(negedge clk);
        src_y = 100; snes_refresh = 0;
        repeat (2) @(negedge clk);
        check("disarmed no pause", pause_snes, 0);

        // sync_en drop mid-pause
        rearm();
        strobe_sync();
        measure(5, n);
        check("sync_en drop length", n, 6);
        check("sync_en drop count", sync_timeouts, 1);
        sync_en = 1;

        // reset in the middle of a pause
        rearm();
        strobe_sync();
        @(negedge clk);
        src_y = 100; snes_refresh = 0;
        check("pause before reset", pause_snes, 1);
        repeat (4) @(negedge clk);
        resetn = 0;
        @(negedge clk);
        check("reset drops pause", pause_snes, 0);
        check("reset clears count", sync_timeouts, 0);
        repeat (10) @(negedge clk);
        check("pixel reset rgb", rgb_out, BORDER);
        resetn = 1;
        repeat (3) @(negedge clk);
        strobe_sync();
        measure(0, n);
        check("re-pause after reset", n, 64);
        check("count after reset", sync_timeouts, 1);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
